// File: rtl/counter_ctrl_v2.sv
// Programmable up/down counter with integrated run-control FSM: one-shot or periodic
// operation, loop limit, pause/resume and abort.
module counter_ctrl_v2 #(
    parameter int unsigned CNT_WIDTH  = 7,
    parameter int unsigned LOOP_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic                  pause_i,
    input  logic                  mode_i,
    input  logic                  dir_i,
    input  logic [CNT_WIDTH-1:0]  cnt_val_i,
    input  logic [LOOP_WIDTH-1:0] loop_val_i,
    output logic [CNT_WIDTH-1:0]  cnt_o,
    output logic [LOOP_WIDTH-1:0] loop_cnt_o,
    output logic                  idle_o,
    output logic                  run_o,
    output logic                  pause_o,
    output logic                  done_o,
    output logic                  period_o
);

    localparam logic [CNT_WIDTH-1:0]  CntOne  = CNT_WIDTH'(1);
    localparam logic [LOOP_WIDTH-1:0] LoopOne = LOOP_WIDTH'(1);

    typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

    state_e                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]  n_q, n_d;
    logic [LOOP_WIDTH-1:0] loop_q, loop_d;
    logic [LOOP_WIDTH-1:0] lim_q, lim_d;
    logic                  mode_q, mode_d;
    logic                  dir_q, dir_d;

    logic [CNT_WIDTH-1:0]  start_val;
    logic [CNT_WIDTH-1:0]  term_val;
    logic [LOOP_WIDTH-1:0] loop_inc;
    logic                  at_term;
    logic                  last_loop;

    // Up counts 0..N-1, down counts N-1..0; the reload value is the opposite end.
    assign start_val = dir_q ? (n_q - CntOne) : '0;
    assign term_val  = dir_q ? '0 : (n_q - CntOne);
    assign at_term   = (cnt_q == term_val);
    assign loop_inc  = loop_q + LoopOne;
    assign last_loop = !mode_q || ((lim_q != '0) && (loop_inc == lim_q));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        loop_d  = loop_q;
        n_d     = n_q;
        lim_d   = lim_q;
        mode_d  = mode_q;
        dir_d   = dir_q;

        unique case (state_q)
            StIdle: begin
                if (start_i && (cnt_val_i != '0)) begin
                    n_d     = cnt_val_i;
                    lim_d   = loop_val_i;
                    mode_d  = mode_i;
                    dir_d   = dir_i;
                    cnt_d   = dir_i ? (cnt_val_i - CntOne) : '0;
                    loop_d  = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (abort_i) begin
                    cnt_d   = '0;
                    loop_d  = '0;
                    state_d = StIdle;
                end else if (pause_i) begin
                    state_d = StPause;
                end else if (at_term) begin
                    loop_d = loop_inc;
                    if (last_loop) begin
                        state_d = StDone;
                    end else begin
                        cnt_d = start_val;
                    end
                end else begin
                    cnt_d = dir_q ? (cnt_q - CntOne) : (cnt_q + CntOne);
                end
            end
            StPause: begin
                if (abort_i) begin
                    cnt_d   = '0;
                    loop_d  = '0;
                    state_d = StIdle;
                end else if (!pause_i) begin
                    state_d = StRun;
                end
            end
            StDone: begin
                // Final values were visible during DONE; clear them on the way out.
                cnt_d   = '0;
                loop_d  = '0;
                state_d = StIdle;
            end
            default: begin
                cnt_d   = '0;
                loop_d  = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            loop_q  <= '0;
            n_q     <= '0;
            lim_q   <= '0;
            mode_q  <= 1'b0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            loop_q  <= loop_d;
            n_q     <= n_d;
            lim_q   <= lim_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
        end
    end

    assign cnt_o      = cnt_q;
    assign loop_cnt_o = loop_q;
    assign idle_o     = (state_q == StIdle);
    assign run_o      = (state_q == StRun);
    assign pause_o    = (state_q == StPause);
    assign done_o     = (state_q == StDone);
    assign period_o   = (state_q == StRun) && !abort_i && !pause_i && at_term;

endmodule
